bitonic_build_stage: RTL and testbench
======================================

Name: bitonic_build_stage

Overview:
- Sequential front end of the bitonic sorter; sits directly upstream of the combinational bitonic merge (last) stage.
- Accepts N elements serially over a valid/ready handshake and buffers them.
- Runs the partial bitonic sort network one compare-exchange layer per cycle, so that the first half is ascending and the second half is descending.
- Presents the resulting bitonic vector as one packed bus with valid/ready to the merge stage.

Parameters:
- N, 16, number of elements; power of two, at least 4.
- W, 1, element width in bits. W=1 matches the merge stage's one-bit-per-element packed vector.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  upstream element valid
- in_ready  output  1  stage can accept an element
- in_data  input  W  element value, unsigned
- out_valid  output  1  bitonic vector available
- out_ready  input  1  downstream consumes the vector
- out_data  output  N*W  bitonic vector; element i at out_data[i*W +: W]

Behaviour:
- Clock/reset (already decided): one clock; reset is asynchronous and active-low.
- Reset values: state=FILL, wr_ptr=0, layer counter=0, buffer=0; in_ready=1, out_valid=0, out_data=0.
- FILL state:
  - in_ready=1.
  - On in_valid&&in_ready: buf[wr_ptr]<=in_data, wr_ptr++.
  - Element 0 is the first one accepted.
  - The accept with wr_ptr==N-1 wraps wr_ptr to 0 and moves to SORT.
- SORT state:
  - in_ready=0.
  - Layer schedule: for k=2,4,...,N/2; for j=k/2 down to 1.
  - Each layer takes one cycle and compare-exchanges every pair (i, i^j) with i<(i^j) in parallel.
  - Ascending if (i&k)==0, which places min at i and max at i^j. Otherwise descending, which places max at i.
  - Ties: no change.
  - Layer count L=log2(N)*(log2(N)-1)/2, which is 6 for N=16.
  - After the last layer: go to HOLD.
- Latency: Nth accept at edge E0; layers applied at E1..EL; out_valid=1 after EL. This is 6 cycles for N=16.
- HOLD state:
  - out_valid=1, in_ready=0.
  - out_data is held stable until the handshake completes.
  - On out_ready: out_valid drops at the next edge and the state returns to FILL with in_ready=1.
  - No overlap: a new element cannot be accepted in the same cycle as the out_ready handshake.
- out_data: driven directly from the buffer register in all states, so no extra output register. It is only meaningful while out_valid=1.
- Boundary conditions:
  - in_valid while in_ready=0: ignored, nothing is consumed.
  - out_ready while out_valid=0: ignored.
  - Reset mid-FILL/SORT/HOLD: partial data is discarded and all registers return to reset values immediately.
  - Equal elements: output is still a valid bitonic sequence.
  - Result property: buf[0..N/2-1] is nondecreasing and buf[N/2..N-1] is nonincreasing.

Optional Feature:
- Macro: BITONIC_BUILD_CHECK_EN.
- Defined:
  - Adds output port bitonic_err (1 bit, reset 0).
  - It is registered on entry to HOLD: 1 if the first half is not nondecreasing or the second half is not nonincreasing; otherwise 0.
  - It stays valid throughout HOLD and clears on leaving HOLD.
- Undefined: no port and no check logic; behaviour is otherwise identical.

Decomposition:
- Package bitonic_pkg holds:
  - state enum {FILL, SORT, HOLD}
  - localparam function for layer count from N
  - functions layer_k(idx) and layer_j(idx), which map the layer counter to (k, j)
  - function cx_ascending(i, k)
- One sub-module: bitonic_cx, a W-bit compare-exchange.
  - Inputs: a, b, dir. Outputs: lo, hi.
  - Instantiated N/2 times per cycle with pairings muxed by the layer counter.

Test Plan:
- Single vector, N=16, W=1: elements in order 1,0,1,0,...,1,0 -> after 6 SORT cycles, out_valid=1 and out_data=16'h0FF0. in_ready=0 during SORT and HOLD.
- Descending-input vector, W=4: elements 15,14,...,0 -> first half 8..15 ascending, second half 7..0 descending. out_data element 0 =8, element 7 =15, element 8 =7, element 15 =0.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_data stable and in_ready=0 throughout. Pulse out_ready -> next cycle out_valid=0 and in_ready=1.
- Gapped input: in_valid toggling every other cycle, plus in_valid asserted during SORT -> exactly 16 elements captured. SORT-cycle data is not consumed, and results match the reference model.
- Reset mid-SORT after layer 3: rst_n low for 1 cycle -> out_valid=0, in_ready=1. A fresh 16-element vector then yields the correct result with no residue from before reset.
- With BITONIC_BUILD_CHECK_EN: random vectors give bitonic_err=0. Forcing a buffer corruption via hierarchical deposit at HOLD entry gives bitonic_err=1.

Source files
------------

// File: rtl/bitonic_pkg.sv
// Shared types and layer-schedule helpers for the bitonic build stage.
package bitonic_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    SORT = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic int layer_count(input int n);
    int lg;
    lg = $clog2(n);
    return lg * (lg - 1) / 2;
  endfunction

  // Layers run k = 2..n/2 (k = 1<<s), and within each k, j = k/2 down to 1.
  function automatic int layer_k(input int idx, input int n);
    int cnt;
    int k;
    cnt = 0;
    k   = 2;
    for (int s = 1; s < $clog2(n); s++) begin
      for (int t = s - 1; t >= 0; t--) begin
        if (cnt == idx) k = 1 << s;
        cnt++;
      end
    end
    return k;
  endfunction

  function automatic int layer_j(input int idx, input int n);
    int cnt;
    int j;
    cnt = 0;
    j   = 1;
    for (int s = 1; s < $clog2(n); s++) begin
      for (int t = s - 1; t >= 0; t--) begin
        if (cnt == idx) j = 1 << t;
        cnt++;
      end
    end
    return j;
  endfunction

  function automatic logic cx_ascending(input int i, input int k);
    return (i & k) == 0;
  endfunction

endpackage

// File: rtl/bitonic_cx.sv
// W-bit compare-exchange: dir=1 puts min on lo / max on hi, dir=0 the reverse.
// Purely combinational; equal inputs pass through unswapped.
module bitonic_cx #(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         dir,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);

  logic w_swap;

  assign w_swap = dir ? (a > b) : (a < b);
  assign lo     = w_swap ? b : a;
  assign hi     = w_swap ? a : b;

endmodule

// File: rtl/bitonic_build_stage.sv
// Serial-in bitonic builder: buffers N elements, runs one compare-exchange layer per cycle,
// holds the bitonic vector until out_ready. Optional BITONIC_BUILD_CHECK_EN adds bitonic_err.
module bitonic_build_stage
  import bitonic_pkg::*;
#(
  parameter int N = 16,
  parameter int W = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_data
`ifdef BITONIC_BUILD_CHECK_EN
  , output logic         bitonic_err
`endif
);

  localparam int LW  = $clog2(N);
  localparam int L   = layer_count(N);
  localparam int LCW = $clog2(L + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LW-1:0]    r_wr_ptr;
  logic [LCW-1:0]   r_layer;
  logic [W-1:0]     r_buf  [N];
  logic [W-1:0]     w_next [N];
  logic [LW-1:0]    w_k;
  logic [LW-1:0]    w_j;
  logic [LW-1:0]    w_pi   [N/2];
  logic [LW-1:0]    w_pm   [N/2];
  logic [W-1:0]     w_lo   [N/2];
  logic [W-1:0]     w_hi   [N/2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FILL;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    unique case (r_state)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && r_wr_ptr == LW'(N - 1)) w_state_nxt = SORT;
      end
      SORT: begin
        if (r_layer == LCW'(L - 1)) w_state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = FILL;
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_comb begin
    w_k = LW'(layer_k(int'(r_layer), N));
    w_j = LW'(layer_j(int'(r_layer), N));
  end

  // Pair p maps to i = p with a zero inserted at bit log2(j); partner is i|j.
  for (genvar p = 0; p < N/2; p++) begin : g_cx
    logic [LW-1:0] w_low;
    logic [W-1:0]  w_a;
    logic [W-1:0]  w_b;
    logic          w_dir;

    assign w_low   = LW'(p) & (w_j - 1'b1);
    assign w_pi[p] = ((LW'(p) & ~(w_j - 1'b1)) << 1) | w_low;
    assign w_pm[p] = w_pi[p] | w_j;
    assign w_a     = r_buf[w_pi[p]];
    assign w_b     = r_buf[w_pm[p]];
    assign w_dir   = cx_ascending(int'(w_pi[p]), int'(w_k));

    bitonic_cx #(.W(W)) u_cx (
      .a   (w_a),
      .b   (w_b),
      .dir (w_dir),
      .lo  (w_lo[p]),
      .hi  (w_hi[p])
    );
  end

  always_comb begin
    w_next = r_buf;
    for (int p = 0; p < N/2; p++) begin
      w_next[w_pi[p]] = w_lo[p];
      w_next[w_pm[p]] = w_hi[p];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_layer  <= '0;
      for (int i = 0; i < N; i++) r_buf[i] <= '0;
    end else begin
      case (r_state)
        FILL: begin
          if (in_valid) begin
            r_buf[r_wr_ptr] <= in_data;
            r_wr_ptr        <= (r_wr_ptr == LW'(N - 1)) ? '0 : r_wr_ptr + 1'b1;
          end
        end
        SORT: begin
          r_buf   <= w_next;
          r_layer <= (r_layer == LCW'(L - 1)) ? '0 : r_layer + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < N; i++) out_data[i*W +: W] = r_buf[i];
  end

`ifdef BITONIC_BUILD_CHECK_EN
  logic w_bad;
  logic r_err;

  // Judged on the value being loaded by the final layer, so the flag is valid on HOLD entry.
  always_comb begin
    w_bad = 1'b0;
    for (int i = 1; i < N/2; i++) if (w_next[i] < w_next[i-1]) w_bad = 1'b1;
    for (int i = N/2 + 1; i < N; i++) if (w_next[i] > w_next[i-1]) w_bad = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (r_state == SORT && w_state_nxt == HOLD) begin
      r_err <= w_bad;
    end else if (r_state == HOLD && w_state_nxt == FILL) begin
      r_err <= 1'b0;
    end
  end

  assign bitonic_err = r_err;
`endif

endmodule

// File: tb/tb_bitonic_build_stage.sv
// Bench for bitonic_build_stage (N=16, W=4): directed table, corner sequences, random vectors
// checked against a sort-based reference (first half ascending, second half descending).
module tb_bitonic_build_stage;

  localparam int N = 16;
  localparam int W = 4;
  localparam int L = 6;

  typedef logic [W-1:0] vec_t [N];
  typedef struct {
    vec_t             din;
    logic [N*W-1:0]   exp;
  } vec_rec_t;

  logic           clk       = 1'b0;
  logic           rst_n     = 1'b0;
  logic           in_valid  = 1'b0;
  logic [W-1:0]   in_data   = '0;
  logic           out_ready = 1'b0;
  logic           in_ready;
  logic           out_valid;
  logic [N*W-1:0] out_data;
`ifdef BITONIC_BUILD_CHECK_EN
  logic           bitonic_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bitonic_build_stage #(.N(N), .W(W)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef BITONIC_BUILD_CHECK_EN
    , .bitonic_err (bitonic_err)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] model(input vec_t v);
    int lo[$];
    int hi[$];
    logic [N*W-1:0] r;
    r = '0;
    for (int i = 0; i < N/2; i++) begin
      lo.push_back(int'(v[i]));
      hi.push_back(int'(v[i + N/2]));
    end
    lo.sort();
    hi.rsort();
    for (int i = 0; i < N/2; i++) begin
      r[i*W +: W]         = W'(lo[i]);
      r[(i + N/2)*W +: W] = W'(hi[i]);
    end
    return r;
  endfunction

  // Called at a negedge in FILL; returns at the negedge just after the Nth accept.
  task automatic send_vec(input vec_t v, input bit gapped, input bit junk_after);
    int bad;
    bad = 0;
    for (int e = 0; e < N; e++) begin
      if (gapped) begin
        in_valid = 1'b0;
        in_data  = W'($urandom);
        @(negedge clk);
      end
      if (in_ready !== 1'b1) bad++;
      in_valid = 1'b1;
      in_data  = v[e];
      @(negedge clk);
    end
    in_valid = junk_after;
    in_data  = W'($urandom);
    check("fill_in_ready", 64'(bad), 64'd0);
    check("sort_entry_in_ready", 64'(in_ready), 64'd0);
  endtask

  task automatic wait_out(output int lat);
    int bad;
    bad = 0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (in_ready !== 1'b0) bad++;
      @(negedge clk);
      lat++;
    end
    check("sort_in_ready_low", 64'(bad), 64'd0);
    check("latency", 64'(lat), 64'(L));
  endtask

  task automatic run_vec(input vec_t v, input logic [N*W-1:0] exp, input bit gapped,
                         input bit junk, input int hold, output logic [N*W-1:0] got);
    int lat;
    int bad;
    send_vec(v, gapped, junk);
    wait_out(lat);
    got = out_data;
    check("out_data", out_data, exp);
    check("hold_in_ready", 64'(in_ready), 64'd0);
`ifdef BITONIC_BUILD_CHECK_EN
    check("bitonic_err", 64'(bitonic_err), 64'd0);
`endif
    bad = 0;
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      if (out_data !== exp || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    if (hold > 0) check("backpressure_hold", 64'(bad), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("handshake_out_valid", 64'(out_valid), 64'd0);
    check("handshake_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    vec_rec_t       recs [4];
    vec_t           v;
    logic [N*W-1:0] got;
    logic [N-1:0]   bitview;

    for (int i = 0; i < N; i++) begin
      recs[0].din[i] = (i % 2 == 0) ? W'(1) : W'(0);
      recs[1].din[i] = W'(N - 1 - i);
      recs[2].din[i] = W'(i);
      recs[3].din[i] = W'(5);
    end
    recs[0].exp = 64'h0000_1111_1111_0000;
    recs[1].exp = 64'h0123_4567_FEDC_BA98;
    recs[2].exp = 64'h89AB_CDEF_7654_3210;
    recs[3].exp = 64'h5555_5555_5555_5555;

    repeat (2) @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data", out_data, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 4; t++) begin
      run_vec(recs[t].din, recs[t].exp, 1'b0, 1'b0, 0, got);
      if (t == 0) begin
        for (int i = 0; i < N; i++) bitview[i] = got[i*W];
        check("alt_pattern_bitview", 64'(bitview), 64'h0FF0);
      end
    end

    // Backpressure: out_ready withheld for 20 cycles, junk in_valid presented during HOLD.
    for (int i = 0; i < N; i++) v[i] = W'($urandom_range(0, 15));
    run_vec(v, model(v), 1'b0, 1'b1, 20, got);

    // Gapped input with in_valid held high through SORT, HOLD and the handshake cycle.
    for (int i = 0; i < N; i++) v[i] = W'($urandom_range(0, 15));
    run_vec(v, model(v), 1'b1, 1'b1, 0, got);
    for (int i = 0; i < N; i++) v[i] = W'($urandom_range(0, 15));
    run_vec(v, model(v), 1'b1, 1'b0, 0, got);

    // Reset after layer 3 of SORT.
    for (int i = 0; i < N; i++) v[i] = W'(15);
    send_vec(v, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midsort_rst_out_valid", 64'(out_valid), 64'd0);
    check("midsort_rst_in_ready", 64'(in_ready), 64'd1);
    check("midsort_rst_out_data", out_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) v[i] = W'($urandom_range(0, 3));
    run_vec(v, model(v), 1'b0, 1'b0, 0, got);

    // Reset mid-FILL: five elements dropped, write pointer must restart at element 0.
    for (int e = 0; e < 5; e++) begin
      in_valid = 1'b1;
      in_data  = W'(15);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) v[i] = W'(i % 7);
    run_vec(v, model(v), 1'b0, 1'b0, 0, got);

    // Random vectors; odd ones use 0/1 values (heavy ties) and keep out_ready high while idle.
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < N; i++)
        v[i] = (r % 2 == 1) ? W'($urandom_range(0, 1)) : W'($urandom_range(0, 15));
      out_ready = (r % 2 == 1);
      run_vec(v, model(v), (r % 4 == 2), (r % 3 == 0), 0, got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
